// File: rtl/seg_scan.sv
// Binary-to-BCD feeder for a multiplexed 7-segment display: a shift-add-3 converter plus a digit scan engine.
// Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZB_EN.
module seg_scan #(
  parameter int NUM_DIG  = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIN_W-1:0]   value,
  input  logic               value_vld,
  output logic               busy,
  output logic [3:0]         d,
  output logic               digit_en,
  output logic [NUM_DIG-1:0] dig_sel_n,
  output logic               ovf
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  function automatic longint max_val();
    longint m = 1;
    for (int i = 0; i < NUM_DIG; i++) m = m * 10;
    return m - 1;
  endfunction
  localparam logic [63:0] MAXV = 64'(max_val());

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;

  logic [BIN_W-1:0]            bin_q, pend_val_q, src, ld_val;
  logic [NUM_DIG-1:0][3:0]     bcd_q, bcd_adj, disp_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        ovfn_q, ovf_q, pend_vld_q, ld_ovf, start;
  logic [PRE_W-1:0]            pre_q, pre_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [3:0]                  d_q;
  logic [NUM_DIG-1:0]          sel_q;
  logic                        en_q, en_d;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (value_vld) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = (value_vld || pend_vld_q) ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    d         = d_q;
    digit_en  = en_q;
    dig_sel_n = sel_q;
    ovf       = ovf_q;
  end

  // A strobe landing in DONE beats the older pending value.
  always_comb begin
    start  = (state_q == IDLE && value_vld) || (state_q == DONE && (value_vld || pend_vld_q));
    src    = (state_q == DONE && !value_vld) ? pend_val_q : value;
    ld_ovf = 64'(src) > MAXV;
    ld_val = ld_ovf ? BIN_W'(MAXV) : src;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIG; i++)
      if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0; bcd_q <= '0; cnt_q <= '0; ovfn_q <= 1'b0;
      pend_vld_q <= 1'b0; pend_val_q <= '0; disp_q <= '0; ovf_q <= 1'b0;
    end else begin
      if (start) begin
        bin_q  <= ld_val;
        bcd_q  <= '0;
        cnt_q  <= CNT_W'(BIN_W);
        ovfn_q <= ld_ovf;
      end else if (state_q == SHIFT) begin
        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
        cnt_q          <= cnt_q - CNT_W'(1);
      end
      if (state_q == DONE) begin
        disp_q     <= bcd_q;
        ovf_q      <= ovfn_q;
        pend_vld_q <= 1'b0;
      end else if (state_q == SHIFT && value_vld) begin
        pend_vld_q <= 1'b1;
        pend_val_q <= value;
      end
    end
  end

  // ---------------- digit scan ----------------
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic lead;
  // Blank a digit only when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    en_d = 1'b1;
    lead = 1'b1;
    for (int i = NUM_DIG - 1; i > 0; i--) begin
      lead = lead && (disp_q[i] == 4'd0);
      if (IDX_W'(i) == idx_d && lead) en_d = 1'b0;
    end
  end
`else
  assign en_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0; idx_q <= '0; d_q <= '0;
      sel_q <= ~NUM_DIG'(1);
      en_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      d_q   <= disp_q[idx_d];
      sel_q <= ~(NUM_DIG'(1) << idx_d);
      en_q  <= en_d;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a cycle-level reference model of load timing, pending and scan, plus directed scenarios.
module tb_seg_scan;
  localparam int NUM_DIG = 4, BIN_W = 14, SCAN_DIV = 4;
  localparam int MAXV = 9999;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, value_vld = 1'b0;
  logic [BIN_W-1:0] value = '0;
  logic busy, digit_en, ovf;
  logic [3:0] d;
  logic [NUM_DIG-1:0] dig_sel_n;

  int n_cmp = 0, n_bad = 0;

  seg_scan #(.NUM_DIG(NUM_DIG), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .value_vld(value_vld), .busy(busy),
    .d(d), .digit_en(digit_en), .dig_sel_n(dig_sel_n), .ovf(ovf));

  always #5 clk = ~clk;

  function automatic int p10(int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic int dig(int v, int i);
    return (v / p10(i)) % 10;
  endfunction

  function automatic int sel2idx(logic [NUM_DIG-1:0] s);
    int r = -1, c = 0;
    for (int i = 0; i < NUM_DIG; i++) if (s[i] === 1'b0) begin r = i; c++; end
    return (c == 1) ? r : -1;
  endfunction

  // Reference model: edge count since reset gives the scan slot; loads commit BIN_W+1 edges after start.
  int m_n, m_idx, m_commit, m_cur, m_pval, m_disp, m_sv;
  bit m_act, m_pend, m_ovf, m_go, mon_on = 1'b0;
  logic e_busy, e_en, e_ovf;
  logic [3:0] e_d;
  logic [NUM_DIG-1:0] e_sel;

  always begin
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_act = 0; m_pend = 0; m_disp = 0; m_ovf = 0;
      e_busy = 0; e_d = 0; e_sel = ~NUM_DIG'(1); e_en = 0; e_ovf = 0; mon_on = 1;
    end else begin
      m_n++;
      m_idx = (m_n / SCAN_DIV) % NUM_DIG;
      e_sel = ~(NUM_DIG'(1) << m_idx);
      e_d   = 4'(dig(m_disp, m_idx));
      e_en  = LZB ? (m_idx == 0 || m_disp / p10(m_idx) != 0) : 1'b1;
      m_go  = 0;
      if (m_act && m_n == m_commit) begin
        m_ovf  = m_cur > MAXV;
        m_disp = m_ovf ? MAXV : m_cur;
        m_act  = 0;
        if (value_vld) begin m_go = 1; m_sv = int'(value); end
        else if (m_pend) begin m_go = 1; m_sv = m_pval; end
        m_pend = 0;
      end else if (!m_act) begin
        if (value_vld) begin m_go = 1; m_sv = int'(value); end
      end else if (value_vld) begin
        m_pend = 1; m_pval = int'(value);
      end
      if (m_go) begin m_act = 1; m_cur = m_sv; m_commit = m_n + BIN_W + 1; end
      e_busy = m_act;
      e_ovf  = m_ovf;
    end
  end

  always begin
    @(negedge clk);
    if (mon_on) begin
      n_cmp++; if (busy !== e_busy) begin n_bad++; $display("FAIL mon_busy t=%0t got %b exp %b", $time, busy, e_busy); end
      n_cmp++; if (d !== e_d) begin n_bad++; $display("FAIL mon_d t=%0t got %h exp %h", $time, d, e_d); end
      n_cmp++; if (dig_sel_n !== e_sel) begin n_bad++; $display("FAIL mon_sel t=%0t got %b exp %b", $time, dig_sel_n, e_sel); end
      n_cmp++; if (digit_en !== e_en) begin n_bad++; $display("FAIL mon_en t=%0t got %b exp %b", $time, digit_en, e_en); end
      n_cmp++; if (ovf !== e_ovf) begin n_bad++; $display("FAIL mon_ovf t=%0t got %b exp %b", $time, ovf, e_ovf); end
    end
  end

  task automatic pulse(input int v);
    value = BIN_W'(v); value_vld = 1'b1;
    @(negedge clk);
    value_vld = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy !== 1'b0 && c < 200) begin @(negedge clk); c++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; value_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || d !== 4'd0 || dig_sel_n !== 4'b1110 || ovf !== 1'b0 || digit_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_vals busy=%b d=%h sel=%b ovf=%b en=%b exp 0 0 1110 0 0", busy, d, dig_sel_n, ovf, digit_en);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (digit_en !== 1'b1 || dig_sel_n !== 4'b1110 || d !== 4'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL post_reset en=%b sel=%b d=%h busy=%b exp 1 1110 0 0", digit_en, dig_sel_n, d, busy);
    end
  endtask

  task automatic test_latency_scan();
    int c, idx, prev, run, chg;
    bit seen;
    pulse(1234);
    c = 0;
    while (busy === 1'b1 && c < 100) begin c++; @(negedge clk); end
    n_cmp++; if (c != BIN_W + 1) begin n_bad++; $display("FAIL busy_len got %0d exp %0d", c, BIN_W + 1); end
    @(negedge clk);
    prev = -1; run = 0; chg = 0; seen = 0;
    for (int k = 0; k < 2 * NUM_DIG * SCAN_DIV + SCAN_DIV; k++) begin
      idx = sel2idx(dig_sel_n);
      n_cmp++;
      if (idx < 0 || d !== 4'(dig(1234, idx))) begin
        n_bad++; $display("FAIL scan_d sel=%b got %h exp digit of 1234", dig_sel_n, d);
      end
      if (prev >= 0 && idx != prev) begin
        n_cmp++; if (idx != (prev + 1) % NUM_DIG) begin n_bad++; $display("FAIL scan_order got %0d exp %0d", idx, (prev + 1) % NUM_DIG); end
        if (seen) begin
          n_cmp++; if (run != SCAN_DIV) begin n_bad++; $display("FAIL slot_len got %0d exp %0d", run, SCAN_DIV); end
        end
        seen = 1; run = 0; chg++;
      end
      run++; prev = idx;
      @(negedge clk);
    end
    n_cmp++; if (chg < 2 * NUM_DIG - 1) begin n_bad++; $display("FAIL scan_changes got %0d exp >= %0d", chg, 2 * NUM_DIG - 1); end
  endtask

  task automatic test_saturation();
    int c, idx;
    pulse(12000);
    wait_idle(c);
    n_cmp++; if (c >= 200) begin n_bad++; $display("FAIL sat_timeout got %0d cycles exp < 200", c); end
    @(negedge clk);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b exp 1", ovf); end
    for (int k = 0; k < NUM_DIG * SCAN_DIV; k++) begin
      n_cmp++; if (d !== 4'd9) begin n_bad++; $display("FAIL sat_d got %h exp 9", d); end
      @(negedge clk);
    end
    pulse(7);
    wait_idle(c);
    @(negedge clk);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL unsat_ovf got %b exp 0", ovf); end
    for (int k = 0; k < NUM_DIG * SCAN_DIV; k++) begin
      idx = sel2idx(dig_sel_n);
      n_cmp++; if (idx < 0 || d !== 4'(dig(7, idx))) begin n_bad++; $display("FAIL unsat_d sel=%b got %h", dig_sel_n, d); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int c, idx;
    bit saw200 = 0;
    pulse(100);
    repeat (2) @(negedge clk);
    pulse(200);
    @(negedge clk);
    pulse(300);
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      idx = sel2idx(dig_sel_n);
      if (idx == 2 && d === 4'd2) saw200 = 1;
      c++; @(negedge clk);
    end
    n_cmp++; if (c != 2 * (BIN_W + 1) - 5) begin n_bad++; $display("FAIL b2b_busy got %0d exp %0d", c, 2 * (BIN_W + 1) - 5); end
    n_cmp++; if (saw200) begin n_bad++; $display("FAIL b2b_dropped got 200 shown exp never"); end
    @(negedge clk);
    for (int k = 0; k < NUM_DIG * SCAN_DIV; k++) begin
      idx = sel2idx(dig_sel_n);
      n_cmp++; if (idx < 0 || d !== 4'(dig(300, idx))) begin n_bad++; $display("FAIL b2b_d sel=%b got %h exp digit of 300", dig_sel_n, d); end
      @(negedge clk);
    end
    // Strobe lands in the DONE cycle of the previous conversion.
    pulse(555);
    repeat (14) @(negedge clk);
    pulse(666);
    wait_idle(c);
    n_cmp++; if (c >= 200) begin n_bad++; $display("FAIL done_strobe_timeout got %0d exp < 200", c); end
    repeat (NUM_DIG * SCAN_DIV + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulse(9999);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || d !== 4'd0) begin n_bad++; $display("FAIL rstmid_now busy=%b d=%h exp 0 0", busy, d); end
    for (int k = 0; k < 2 * NUM_DIG * SCAN_DIV + BIN_W + 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || d !== 4'd0 || ovf !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_stale busy=%b d=%h ovf=%b exp 0 0 0", busy, d, ovf);
      end
    end
  endtask

  task automatic test_lzb();
    int c, idx;
    logic exp_en;
    pulse(40);
    wait_idle(c);
    @(negedge clk);
    for (int k = 0; k < NUM_DIG * SCAN_DIV; k++) begin
      idx = sel2idx(dig_sel_n);
      exp_en = LZB ? (idx >= 0 && idx <= 1) : 1'b1;
      n_cmp++; if (digit_en !== exp_en) begin n_bad++; $display("FAIL lzb40 sel=%b got %b exp %b", dig_sel_n, digit_en, exp_en); end
      @(negedge clk);
    end
    pulse(0);
    wait_idle(c);
    @(negedge clk);
    for (int k = 0; k < NUM_DIG * SCAN_DIV; k++) begin
      idx = sel2idx(dig_sel_n);
      exp_en = LZB ? (idx == 0) : 1'b1;
      n_cmp++; if (digit_en !== exp_en || d !== 4'd0) begin n_bad++; $display("FAIL lzb0 sel=%b got en=%b d=%h exp en=%b d=0", dig_sel_n, digit_en, d, exp_en); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int c, v;
    for (int k = 0; k < 60; k++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      pulse(v);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle(c);
    n_cmp++; if (c >= 200) begin n_bad++; $display("FAIL rand_timeout got %0d exp < 200", c); end
    repeat (NUM_DIG * SCAN_DIV + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency_scan();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Upstream feeder for the 7-segment decoder.
- Accepts a binary game value (score/timer) and converts it to BCD with a sequential shift-add-3 engine.
- Time-multiplexes the BCD digits onto one shared 4-bit decoder input with an active-low digit select.
- Drives the decoder's enable input (high = show segments).

Parameters:
- NUM_DIG, 4: number of display digits.
- BIN_W, 14: binary input width.
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz). Minimum 2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- value  in  BIN_W  binary value to display.
- value_vld  in  1  one-cycle load strobe for value.
- busy  out  1  conversion in progress.
- d  out  4  BCD nibble of the currently selected digit, to the decoder data input.
- digit_en  out  1  decoder enable; 1 = segments lit, 0 = blank.
- dig_sel_n  out  NUM_DIG  one-hot-low digit select; bit 0 = least significant digit.
- ovf  out  1  last loaded value exceeded 10^NUM_DIG-1.

Behaviour:
- Reset values (synchronous, rst=1 sampled at a clk edge):
  - busy=0, d=0, digit_en=0, dig_sel_n = all ones except bit0=0, ovf=0.
  - Display register = 0, pending = empty, prescaler = 0, digit index = 0.
  - First cycle after reset release: digit_en=1.
- Conversion FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On value_vld=1: latch value. If value > 10^NUM_DIG-1, substitute all-9s and set internal ovf_n=1; else ovf_n=0.
  - Clear BCD shift register, load bit counter = BIN_W, go to SHIFT, busy=1 next cycle.
- SHIFT (one bit per cycle):
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - Counter decrements; leave for DONE after exactly BIN_W SHIFT cycles.
- DONE (one cycle):
  - Copy BCD to the display register and ovf_n to ovf atomically; busy=0 next cycle.
  - If pending is valid, go to SHIFT with the pending value and clear pending; else go to IDLE.
- Latency: value_vld at cycle t → display register and ovf updated at edge t+BIN_W+2.
- value_vld while busy: stored in a one-deep pending register; a later strobe overwrites it (last wins). Never dropped silently, never queued deeper.
- value_vld in the same cycle as DONE: treated as pending, started immediately.
- Scan engine (independent of the FSM):
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count: index advances and wraps NUM_DIG-1 → 0.
  - dig_sel_n = ~(1 << index); d = display nibble[index]. Both registered and change on the same edge.
- Display register update mid-slot: d reflects the new nibble the next cycle without disturbing scan timing.
- Reset mid-conversion: conversion aborts, pending is cleared, display returns to 0.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: digit_en=0 while the selected digit is a zero with only zeros in all more-significant digits. Digit 0 is never blanked, so value 0 shows "0".
- Undefined: digit_en=1 at all times after reset; leading zeros are shown.

Test Plan:
- Reset then idle: rst high 3 cycles, release → d=0, dig_sel_n=1110, busy=0, ovf=0; digit_en=1 from the next cycle.
- Conversion latency and scan order: value=1234, value_vld at t (SCAN_DIV=4) → busy high t+1..t+BIN_W+1, low at t+BIN_W+2. Scan yields d=4,3,2,1 with dig_sel_n 1110,1101,1011,0111, 4 cycles each, then wraps.
- Saturation: value=12000 → all digits d=9, ovf=1; then value=7 → d=7,0,0,0 and ovf=0.
- Back-to-back loads: value_vld with 100 at t, 200 at t+3, 300 at t+5 → displays 100 then 300; 200 never appears; busy stays high continuously through both conversions.
- Reset mid-conversion: value=9999, rst at t+5 → busy=0 and display 0 after release; no stale 9999 appears.
- SEG_SCAN_LZB_EN defined, value=40 → digit_en=0 on digits 3 and 2, 1 on digits 1 and 0. Value=0 → only digit 0 lit.
